cp0_regfile: RTL and testbench
==============================

Name: cp0_regfile

Overview:
- Coprocessor-0 register file and exception/interrupt controller for the 5-stage MIPS pipeline.
- Sits at the M stage and feeds the next-PC selector:
  - req forces the fetch address to the handler at 0x0000_4180.
  - epc is the eret return target.
- Holds SR, Cause, EPC and PRId, serves mfc0/mtc0, and arbitrates hardware interrupts against synchronous exceptions.

Parameters:
PRID, 32'h0000_2019, read-only processor ID returned for register 15
EXC_NONE, 5'd0, exc_code value meaning "no exception"

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
rd_addr  input  5  mfc0 source register number
wr_addr  input  5  mtc0 destination register number
wr_data  input  32  mtc0 write data
we  input  1  mtc0 write enable
pc_m  input  32  PC of the instruction currently in M
bd_m  input  1  instruction in M is in a branch delay slot
exc_code_m  input  5  ExcCode of the instruction in M; 0 = none
hw_int  input  6  external interrupt lines HW[7:2], level-sensitive
eret  input  1  eret in M
req  output  1  take exception/interrupt this cycle (combinational)
epc  output  32  current EPC register value
rd_data  output  32  mfc0 read data (combinational)

Behaviour:
Register layout:
- SR (12): IM=[15:10], EXL=[1], IE=[0]; all other bits read 0 and ignore writes.
- Cause (13): BD=[31], IP=[15:10], ExcCode=[6:2]; all other bits read 0; software-read-only.
- EPC (14): 32-bit, fully writable.
- PRId (15): constant PRID.
- Any other rd_addr reads 0. Writes to other addresses, Cause or PRId are ignored.

Reset:
- SR, Cause and EPC clear to 0 on the clk edge when reset=1.
- req=0 after reset with hw_int=0 and exc_code_m=0.

Request logic (combinational, same cycle):
- int_pend = |(hw_int & SR.IM) & SR.IE & ~SR.EXL
- exc_pend = (exc_code_m != EXC_NONE) & ~SR.EXL
- req = int_pend | exc_pend

Cause.IP:
- Samples hw_int every cycle, independent of IM, IE and EXL.

On clock edge with req=1 (highest priority; the mtc0 write is suppressed that cycle):
- SR.EXL <= 1
- Cause.ExcCode <= 0 if int_pend, else exc_code_m. An interrupt wins over a simultaneous exception.
- Cause.BD <= bd_m
- EPC <= bd_m ? (pc_m - 4) : pc_m, computed as 32-bit wrap-around subtraction.

On clock edge with req=0 and eret=1:
- SR.EXL <= 0. Other fields unchanged.
- eret together with we: apply the mtc0 write, then force EXL to 0.

On clock edge with req=0, eret=0, we=1:
- Write SR or EPC as masked above.
- A write to SR takes effect for req evaluation on the next cycle.

Read path:
- rd_data reflects register state before this edge. A same-cycle write is not forwarded.
- Cause.IP reads the value registered on the previous edge.

EXL semantics:
- While EXL=1, no request is raised, even if exc_code_m != 0. Nested exceptions are dropped.

Reset mid-handler:
- reset overrides req, eret and we in the same cycle.

Decomposition:
- Shared package holds:
  - CP0 register numbers: SR=12, CAUSE=13, EPC=14, PRID=15.
  - Bit positions and masks for IM, EXL, IE, BD, IP and ExcCode.
  - Handler address 32'h0000_4180.
  - ExcCode constants: Int=0, AdEL=4, AdES=5, RI=10, Ov=12.
- No sub-module is needed. The request arbiter stays inline as continuous assignments.

Test Plan:
1. reset=1 for 2 cycles, then release -> rd_data=0 for addrs 12/13/14, rd_data=32'h0000_2019 for addr 15, req=0.
2. mtc0 SR=32'h0000_0401 (IM[2], IE), then hw_int=6'b000001, pc_m=32'h0000_3008, bd_m=0 -> req=1 that cycle. Next cycle: EPC=32'h0000_3008, Cause.ExcCode=0, Cause.IP[10]=1, SR.EXL=1, req=0.
3. exc_code_m=12, pc_m=32'h0000_3010, bd_m=1, IE=0 -> req=1. Next cycle: EPC=32'h0000_300C, Cause=32'h8000_0030.
4. Simultaneous enabled interrupt and exc_code_m=4 -> ExcCode=0. Also drive we=1 to EPC with 32'hDEAD_BEEF in the same cycle -> write ignored, EPC=pc_m.
5. With EXL=1, assert exc_code_m=10 and an enabled hw_int -> req stays 0. Pulse eret -> EXL=0 and req=1 on the following cycle while hw_int is still held.
6. mtc0 writes 32'hFFFF_FFFF to addrs 12, 13 and 15 -> SR reads 32'h0000_FC03; Cause and PRId unchanged.

Source files
------------

// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: register numbers, field positions, handler address
// and exception codes used by the register file and its surroundings.
package cp0_regfile_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam int SR_IM_LSB     = 10;
    localparam int SR_IM_MSB     = 15;
    localparam int SR_EXL_BIT    = 1;
    localparam int SR_IE_BIT     = 0;
    localparam int CAUSE_BD_BIT  = 31;
    localparam int CAUSE_IP_LSB  = 10;
    localparam int CAUSE_IP_MSB  = 15;
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_EXC_MSB = 6;

    localparam logic [31:0] SR_MASK    = 32'h0000_FC03;
    localparam logic [31:0] CAUSE_MASK = 32'h8000_FC7C;

    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    // A delay-slot instruction restarts at its branch so the branch re-executes.
    function automatic logic [31:0] epc_target(input logic [31:0] pc, input logic bd);
        return bd ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/cp0_regfile.sv
// CP0 register file (SR, Cause, EPC, PRId) with the M-stage exception /
// interrupt request arbiter feeding the next-PC selector.
module cp0_regfile
    import cp0_regfile_pkg::*;
#(
    parameter logic [31:0] PRID     = 32'h0000_2019,
    parameter logic [4:0]  EXC_NONE = 5'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rd_addr,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        we,
    input  logic [31:0] pc_m,
    input  logic        bd_m,
    input  logic [4:0]  exc_code_m,
    input  logic [5:0]  hw_int,
    input  logic        eret,
    output logic        req,
    output logic [31:0] epc,
    output logic [31:0] rd_data
);

    logic [5:0]  r_sr_im;
    logic        r_sr_exl;
    logic        r_sr_ie;
    logic        r_cause_bd;
    logic [5:0]  r_cause_ip;
    logic [4:0]  r_cause_exc;
    logic [31:0] r_epc;

    logic        w_int_pend;
    logic        w_exc_pend;
    logic [31:0] w_sr;
    logic [31:0] w_cause;

    assign w_int_pend = (|(hw_int & r_sr_im)) & r_sr_ie & ~r_sr_exl;
    assign w_exc_pend = (exc_code_m != EXC_NONE) & ~r_sr_exl;
    assign req        = w_int_pend | w_exc_pend;
    assign epc        = r_epc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr_im     <= '0;
            r_sr_exl    <= 1'b0;
            r_sr_ie     <= 1'b0;
            r_cause_bd  <= 1'b0;
            r_cause_ip  <= '0;
            r_cause_exc <= '0;
            r_epc       <= '0;
        end else begin
            r_cause_ip <= hw_int;
            if (req) begin
                r_sr_exl    <= 1'b1;
                r_cause_exc <= w_int_pend ? EXC_INT : exc_code_m;
                r_cause_bd  <= bd_m;
                r_epc       <= epc_target(pc_m, bd_m);
            end else begin
                if (we) begin
                    case (wr_addr)
                        CP0_SR: begin
                            r_sr_im  <= wr_data[SR_IM_MSB:SR_IM_LSB];
                            r_sr_exl <= wr_data[SR_EXL_BIT];
                            r_sr_ie  <= wr_data[SR_IE_BIT];
                        end
                        CP0_EPC: r_epc <= wr_data;
                        default: ;
                    endcase
                end
                // eret clears EXL after any same-cycle SR write.
                if (eret) r_sr_exl <= 1'b0;
            end
        end
    end

    always_comb begin
        w_sr = '0;
        w_sr[SR_IM_MSB:SR_IM_LSB] = r_sr_im;
        w_sr[SR_EXL_BIT]          = r_sr_exl;
        w_sr[SR_IE_BIT]           = r_sr_ie;
    end

    always_comb begin
        w_cause = '0;
        w_cause[CAUSE_BD_BIT]                = r_cause_bd;
        w_cause[CAUSE_IP_MSB:CAUSE_IP_LSB]   = r_cause_ip;
        w_cause[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = r_cause_exc;
    end

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            CP0_SR:    rd_data = w_sr;
            CP0_CAUSE: rd_data = w_cause;
            CP0_EPC:   rd_data = r_epc;
            CP0_PRID:  rd_data = PRID;
            default:   rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed-vector bench for cp0_regfile with hand-computed expectations.
module tb_cp0_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rd_addr;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        we;
    logic [31:0] pc_m;
    logic        bd_m;
    logic [4:0]  exc_code_m;
    logic [5:0]  hw_int;
    logic        eret;
    logic        req;
    logic [31:0] epc;
    logic [31:0] rd_data;

    int n_vec = 0;
    int n_bad = 0;

    cp0_regfile dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .wr_addr(wr_addr),
        .wr_data(wr_data), .we(we), .pc_m(pc_m), .bd_m(bd_m),
        .exc_code_m(exc_code_m), .hw_int(hw_int), .eret(eret),
        .req(req), .epc(epc), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        rd_addr = a;
        #1;
        chk(tag, rd_data, exp);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; wr_addr = a; wr_data = d;
        tick();
        we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rd_addr = '0; wr_addr = '0; wr_data = '0; we = 1'b0;
        pc_m = '0; bd_m = 1'b0; exc_code_m = '0; hw_int = '0; eret = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // reset state
        rd("rst_sr", 5'd12, 32'h0);
        rd("rst_cause", 5'd13, 32'h0);
        rd("rst_epc", 5'd14, 32'h0);
        rd("rst_prid", 5'd15, 32'h0000_2019);
        rd("rst_other", 5'd3, 32'h0);
        chk("rst_req", {31'b0, req}, 32'h0);

        // enabled interrupt
        mtc0(5'd12, 32'h0000_0401);
        rd("sr_wr", 5'd12, 32'h0000_0401);
        hw_int = 6'b000001; pc_m = 32'h0000_3008; bd_m = 1'b0;
        #1 chk("int_req", {31'b0, req}, 32'h1);
        tick();
        chk("int_epc", epc, 32'h0000_3008);
        rd("int_cause", 5'd13, 32'h0000_0400);
        rd("int_sr", 5'd12, 32'h0000_0403);
        chk("int_req_exl", {31'b0, req}, 32'h0);

        // exception in delay slot, interrupts disabled
        hw_int = '0;
        mtc0(5'd12, 32'h0000_0000);
        exc_code_m = 5'd12; pc_m = 32'h0000_3010; bd_m = 1'b1;
        #1 chk("ov_req", {31'b0, req}, 32'h1);
        tick();
        exc_code_m = '0; bd_m = 1'b0;
        chk("ov_epc", epc, 32'h0000_300C);
        rd("ov_cause", 5'd13, 32'h8000_0030);

        // interrupt beats exception; same-cycle mtc0 EPC suppressed
        mtc0(5'd12, 32'h0000_0401);
        hw_int = 6'b000001; exc_code_m = 5'd4; pc_m = 32'h0000_3020; bd_m = 1'b0;
        we = 1'b1; wr_addr = 5'd14; wr_data = 32'hDEAD_BEEF;
        #1 chk("pri_req", {31'b0, req}, 32'h1);
        tick();
        we = 1'b0; exc_code_m = '0;
        chk("pri_epc", epc, 32'h0000_3020);
        rd("pri_cause", 5'd13, 32'h0000_0400);

        // EXL masks everything; eret reopens
        exc_code_m = 5'd10;
        #1 chk("exl_req", {31'b0, req}, 32'h0);
        tick();
        exc_code_m = '0;
        chk("exl_epc", epc, 32'h0000_3020);
        rd("exl_cause", 5'd13, 32'h0000_0400);
        eret = 1'b1;
        #1 chk("eret_req0", {31'b0, req}, 32'h0);
        tick();
        eret = 1'b0;
        rd("eret_sr", 5'd12, 32'h0000_0401);
        chk("eret_req1", {31'b0, req}, 32'h1);
        hw_int = '0;
        #1 chk("eret_req_off", {31'b0, req}, 32'h0);

        // write masking
        mtc0(5'd12, 32'hFFFF_FFFF);
        mtc0(5'd13, 32'hFFFF_FFFF);
        mtc0(5'd15, 32'hFFFF_FFFF);
        rd("mask_sr", 5'd12, 32'h0000_FC03);
        rd("mask_cause", 5'd13, 32'h0000_0000);
        rd("mask_prid", 5'd15, 32'h0000_2019);

        // eret together with mtc0 SR: write applied, EXL still cleared
        we = 1'b1; wr_addr = 5'd12; wr_data = 32'h0000_0803; eret = 1'b1;
        tick();
        we = 1'b0; eret = 1'b0;
        rd("eret_we_sr", 5'd12, 32'h0000_0801);

        // delay-slot EPC wraps below zero
        exc_code_m = 5'd5; pc_m = 32'h0000_0000; bd_m = 1'b1;
        #1 chk("wrap_req", {31'b0, req}, 32'h1);
        tick();
        exc_code_m = '0; bd_m = 1'b0;
        chk("wrap_epc", epc, 32'hFFFF_FFFC);
        rd("wrap_cause", 5'd13, 32'h8000_0014);

        // reset overrides eret and mtc0
        reset = 1'b1; eret = 1'b1; we = 1'b1; wr_addr = 5'd14; wr_data = 32'h1234_5678;
        tick();
        reset = 1'b0; eret = 1'b0; we = 1'b0;
        chk("mid_rst_epc", epc, 32'h0);
        rd("mid_rst_sr", 5'd12, 32'h0);
        rd("mid_rst_cause", 5'd13, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
